as_dst_port_decoder: RTL and testbench

Egress-side counterpart of the output-port-lookup stage: consumes packets whose IOQ module header already carries the destination-port bitmap, decodes that bitmap and presents it as sideband for the current packet. Forwards well-formed packets unchanged with one cycle of latency. Discards packets that have no destination or no leading IOQ header, and checks the header word length against the actual payload length. Sits between the output-port-lookup stage and the output queues.

---
 rtl/as_dst_port_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_as_dst_port_decoder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/as_dst_port_decoder.sv
// as_dst_port_decoder
// Decodes the destination-port bitmap carried in the leading IOQ module header
// and presents it as sideband for the packet being forwarded. Well-formed
// packets pass through unchanged with one cycle of latency. Packets with an
// empty bitmap or without a leading IOQ header are discarded. The header
// word-length field is checked against the real payload length.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   in_data/in_ctrl/in_wr     upstream word, control and write strobe
//   in_rdy                    combinational copy of out_rdy
//   out_data/out_ctrl/out_wr  registered downstream word, control and strobe
//   out_rdy                   downstream ready (nearly-full semantics)
//   out_dst_ports             destination bitmap of the forwarded packet
//   out_dst_valid             bitmap valid from header output through EOP output
//   pkt_cnt, drop_cnt,
//   hdr_err_cnt, len_err_cnt  wrapping 32-bit event counters
module as_dst_port_decoder #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned NUM_OUTPUT_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(8'hFF),
  parameter int unsigned DST_PORT_POS      = 48,
  parameter int unsigned WORD_LEN_POS      = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_dst_ports,
  output logic                         out_dst_valid,
  output logic [31:0]                  pkt_cnt,
  output logic [31:0]                  drop_cnt,
  output logic [31:0]                  hdr_err_cnt,
  output logic [31:0]                  len_err_cnt
);

  localparam int unsigned WC_W   = 16;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDRS,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t state, state_nxt;

  logic [WC_W-1:0]              wlen;
  logic [WC_W-1:0]              wc;
  logic [WC_W-1:0]              wc_inc;
  logic                         drop_seen_zero;
  logic                         valid_clear;

  logic [NUM_OUTPUT_QUEUES-1:0] hdr_bm;
  logic [WC_W-1:0]              hdr_wlen;
  logic                         ctrl_zero;
  logic                         is_ioq;

  logic                         forward;
  logic                         load_hdr;
  logic                         start_payload;
  logic                         count_word;
  logic                         eop;
  logic                         enter_drop;
  logic                         inc_drop;
  logic                         inc_hdr_err;
  logic                         len_mismatch;

  // Pure flow-through backpressure
  assign in_rdy = out_rdy;

  // Header field extraction and word classification
  assign hdr_bm    = in_data[DST_PORT_POS +: NUM_OUTPUT_QUEUES];
  assign hdr_wlen  = in_data[WORD_LEN_POS +: WC_W];
  assign ctrl_zero = (in_ctrl == '0);
  assign is_ioq    = (in_ctrl == IOQ_CTRL);

  // Saturating payload word counter increment
  assign wc_inc = (wc == {WC_W{1'b1}}) ? wc : wc + WC_W'(1);

  // EOP word is counted, so compare the incremented count
  assign len_mismatch = eop && (wc_inc != wlen);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and per-word decisions
  always_comb begin
    state_nxt     = state;
    forward       = 1'b0;
    load_hdr      = 1'b0;
    start_payload = 1'b0;
    count_word    = 1'b0;
    eop           = 1'b0;
    enter_drop    = 1'b0;
    inc_drop      = 1'b0;
    inc_hdr_err   = 1'b0;
    if (in_wr) begin
      case (state)
        S_IDLE: begin
          if (is_ioq) begin
            if (hdr_bm != '0) begin
              forward   = 1'b1;
              load_hdr  = 1'b1;
              state_nxt = S_HDRS;
            end else begin
              inc_drop   = 1'b1;
              enter_drop = 1'b1;
              state_nxt  = S_DROP;
            end
          end else begin
            inc_hdr_err = 1'b1;
            enter_drop  = 1'b1;
            state_nxt   = S_DROP;
          end
        end
        S_HDRS: begin
          forward = 1'b1;
          if (ctrl_zero) begin
            start_payload = 1'b1;
            state_nxt     = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          forward    = 1'b1;
          count_word = 1'b1;
          if (!ctrl_zero) begin
            eop       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_DROP: begin
          if (!ctrl_zero && drop_seen_zero) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output word register; data/ctrl track every written word, strobe only forwarded ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= in_wr & forward;
      if (in_wr) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end
    end
  end

  // Destination sideband; valid drops one edge after the EOP output unless a new header reloads it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_dst_ports <= '0;
      out_dst_valid <= 1'b0;
      valid_clear   <= 1'b0;
      wlen          <= '0;
    end else begin
      valid_clear <= eop;
      if (load_hdr) begin
        out_dst_ports <= hdr_bm;
        out_dst_valid <= 1'b1;
        wlen          <= hdr_wlen;
      end else if (valid_clear) begin
        out_dst_valid <= 1'b0;
      end
    end
  end

  // Payload word count and drop-termination tracking
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wc             <= '0;
      drop_seen_zero <= 1'b0;
    end else begin
      if (start_payload)   wc <= WC_W'(1);
      else if (count_word) wc <= wc_inc;

      // The word that opens a drop may itself be a zero-ctrl leftover
      if (enter_drop)
        drop_seen_zero <= ctrl_zero;
      else if (in_wr && (state == S_DROP) && ctrl_zero)
        drop_seen_zero <= 1'b1;
    end
  end

  // Event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt     <= '0;
      drop_cnt    <= '0;
      hdr_err_cnt <= '0;
      len_err_cnt <= '0;
    end else begin
      if (eop)          pkt_cnt     <= pkt_cnt + CNT_W'(1);
      if (inc_drop)     drop_cnt    <= drop_cnt + CNT_W'(1);
      if (inc_hdr_err)  hdr_err_cnt <= hdr_err_cnt + CNT_W'(1);
      if (len_mismatch) len_err_cnt <= len_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_as_dst_port_decoder.sv
// Directed self-checking bench for as_dst_port_decoder.
module tb_as_dst_port_decoder;

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [7:0]  out_dst_ports;
  logic        out_dst_valid;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] hdr_err_cnt;
  logic [31:0] len_err_cnt;

  int tests_run;
  int failures;

  as_dst_port_decoder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .out_dst_ports (out_dst_ports),
    .out_dst_valid (out_dst_valid),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt),
    .hdr_err_cnt   (hdr_err_cnt),
    .len_err_cnt   (len_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IOQ header word: bitmap at [55:48], word length at [47:32]
  function automatic logic [63:0] mk_hdr(input logic [7:0] bm, input logic [15:0] wl);
    return {8'hA5, bm, wl, 32'h1234_5678};
  endfunction

  // Present one word, let one edge pass, return 1 time unit after the edge
  task automatic drive(input logic wr, input logic [7:0] c, input logic [63:0] d);
    in_wr   = wr;
    in_ctrl = c;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [209:0] got;
    reset_n = 1'b0;
    out_rdy = 1'b1;
    in_wr   = 1'b0;
    in_ctrl = '0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    got = {out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid,
           pkt_cnt, drop_cnt, hdr_err_cnt, len_err_cnt};
    tests_run++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0]  c[5];
    logic [63:0] d[5];
    logic [81:0] got, exp;
    c = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h80};
    d = '{mk_hdr(8'h04, 16'd3), 64'h4040_0000_0000_0001, 64'h1111_2222_3333_4444,
          64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, c[i], d[i]);
      got = {out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid};
      exp = {1'b1, c[i], d[i], 8'h04, 1'b1};
      tests_run++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single_word%0d got=%h exp=%h", i, got, exp);
      end
    end
    tests_run++;
    if ({pkt_cnt, len_err_cnt} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL single_counters pkt=%0d len_err=%0d exp 1/0", pkt_cnt, len_err_cnt);
    end
    drive(1'b0, 8'h80, d[4]);
    got = {out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid};
    exp = {1'b0, 8'h80, d[4], 8'h04, 1'b0};
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL single_after_eop got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_drop_bm0();
    logic [7:0]  c[3];
    logic [63:0] d[3];
    c = '{8'hFF, 8'h00, 8'h80};
    d = '{mk_hdr(8'h00, 16'd2), 64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0002};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, c[i], d[i]);
      tests_run++;
      if (out_wr !== 1'b0) begin
        failures++;
        $display("FAIL bm0_word%0d out_wr=%b exp 0", i, out_wr);
      end
      if (i == 0) begin
        tests_run++;
        if (drop_cnt !== 32'd1) begin
          failures++;
          $display("FAIL bm0_drop_cnt got=%0d exp 1", drop_cnt);
        end
      end
    end
    c = '{8'hFF, 8'h00, 8'h80};
    d = '{mk_hdr(8'h02, 16'd2), 64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0002};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, c[i], d[i]);
      tests_run++;
      if ({out_wr, out_ctrl, out_data, out_dst_ports} !== {1'b1, c[i], d[i], 8'h02}) begin
        failures++;
        $display("FAIL bm0_next_word%0d wr=%b ctrl=%h data=%h ports=%h exp wr=1 ctrl=%h data=%h ports=02",
                 i, out_wr, out_ctrl, out_data, out_dst_ports, c[i], d[i]);
      end
    end
    tests_run++;
    if ({pkt_cnt, drop_cnt} !== {32'd2, 32'd1}) begin
      failures++;
      $display("FAIL bm0_counters pkt=%0d drop=%0d exp 2/1", pkt_cnt, drop_cnt);
    end
  endtask

  task automatic test_no_hdr();
    logic [7:0] c[4];
    c = '{8'h01, 8'h00, 8'h00, 8'h80};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, c[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      tests_run++;
      if (out_wr !== 1'b0) begin
        failures++;
        $display("FAIL nohdr_word%0d out_wr=%b exp 0", i, out_wr);
      end
    end
    tests_run++;
    if (hdr_err_cnt !== 32'd1) begin
      failures++;
      $display("FAIL nohdr_hdr_err got=%0d exp 1", hdr_err_cnt);
    end
    // Back in IDLE: a fresh header is forwarded immediately
    drive(1'b1, 8'hFF, mk_hdr(8'h08, 16'd2));
    tests_run++;
    if ({out_wr, out_dst_ports, out_dst_valid} !== {1'b1, 8'h08, 1'b1}) begin
      failures++;
      $display("FAIL nohdr_next_hdr wr=%b ports=%h valid=%b exp 1/08/1", out_wr, out_dst_ports, out_dst_valid);
    end
    drive(1'b1, 8'h00, 64'h1);
    drive(1'b1, 8'h80, 64'h2);
    tests_run++;
    if ({pkt_cnt, len_err_cnt, hdr_err_cnt} !== {32'd3, 32'd0, 32'd1}) begin
      failures++;
      $display("FAIL nohdr_counters pkt=%0d len_err=%0d hdr_err=%0d exp 3/0/1", pkt_cnt, len_err_cnt, hdr_err_cnt);
    end
  endtask

  task automatic test_len_err();
    logic [7:0]  c[4];
    logic [63:0] d[4];
    c = '{8'hFF, 8'h00, 8'h00, 8'h80};
    d = '{mk_hdr(8'h20, 16'd4), 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, c[i], d[i]);
      tests_run++;
      if ({out_wr, out_ctrl, out_data} !== {1'b1, c[i], d[i]}) begin
        failures++;
        $display("FAIL lenerr_word%0d wr=%b ctrl=%h data=%h exp 1/%h/%h", i, out_wr, out_ctrl, out_data, c[i], d[i]);
      end
    end
    tests_run++;
    if ({pkt_cnt, len_err_cnt} !== {32'd4, 32'd1}) begin
      failures++;
      $display("FAIL lenerr_counters pkt=%0d len_err=%0d exp 4/1", pkt_cnt, len_err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic        r[10];
    logic        w[10];
    logic [7:0]  c[10];
    logic [63:0] d[10];
    logic [7:0]  ep[10];
    logic        ev[10];
    logic [63:0] last_d;
    logic [7:0]  last_c;
    logic [81:0] got, exp;
    r  = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 0};
    w  = '{1, 0, 1, 0, 1, 1, 0, 1, 1, 0};
    c  = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h00};
    d  = '{mk_hdr(8'h01, 16'd2), 64'h0, 64'hA1, 64'h0, 64'hA2,
           mk_hdr(8'h10, 16'd2), 64'h0, 64'hB1, 64'hB2, 64'h0};
    ep = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
    ev = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    last_d = out_data;
    last_c = out_ctrl;
    for (int i = 0; i < 10; i++) begin
      out_rdy = r[i];
      in_wr   = w[i];
      in_ctrl = c[i];
      in_data = d[i];
      #1;
      tests_run++;
      if (in_rdy !== r[i]) begin
        failures++;
        $display("FAIL b2b_in_rdy%0d got=%b exp=%b", i, in_rdy, r[i]);
      end
      @(posedge clk);
      #1;
      if (w[i]) begin
        last_d = d[i];
        last_c = c[i];
      end
      got = {out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid};
      exp = {w[i], last_c, last_d, ep[i], ev[i]};
      tests_run++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%h exp=%h", i, got, exp);
      end
    end
    out_rdy = 1'b1;
    tests_run++;
    if ({pkt_cnt, len_err_cnt} !== {32'd6, 32'd1}) begin
      failures++;
      $display("FAIL b2b_counters pkt=%0d len_err=%0d exp 6/1", pkt_cnt, len_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [209:0] got;
    logic [7:0]   c[3];
    logic [63:0]  d[3];
    drive(1'b1, 8'hFF, mk_hdr(8'h04, 16'd3));
    drive(1'b1, 8'h00, 64'h5151);
    in_wr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    got = {out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid,
           pkt_cnt, drop_cnt, hdr_err_cnt, len_err_cnt};
    tests_run++;
    if (got !== '0) begin
      failures++;
      $display("FAIL rstmid_clear got=%h exp=0", got);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 8'h00, 64'h5252);
    tests_run++;
    if ({out_wr, hdr_err_cnt} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL rstmid_leftover0 wr=%b hdr_err=%0d exp 0/1", out_wr, hdr_err_cnt);
    end
    drive(1'b1, 8'h80, 64'h5353);
    tests_run++;
    if ({out_wr, hdr_err_cnt} !== {1'b0, 32'd1}) begin
      failures++;
      $display("FAIL rstmid_leftover1 wr=%b hdr_err=%0d exp 0/1", out_wr, hdr_err_cnt);
    end
    c = '{8'hFF, 8'h00, 8'h80};
    d = '{mk_hdr(8'h02, 16'd2), 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0002};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, c[i], d[i]);
      tests_run++;
      if ({out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid} !== {1'b1, c[i], d[i], 8'h02, 1'b1}) begin
        failures++;
        $display("FAIL rstmid_next_word%0d wr=%b ctrl=%h data=%h ports=%h valid=%b exp 1/%h/%h/02/1",
                 i, out_wr, out_ctrl, out_data, out_dst_ports, out_dst_valid, c[i], d[i]);
      end
    end
    in_wr = 1'b0;
    tests_run++;
    if ({pkt_cnt, drop_cnt, hdr_err_cnt, len_err_cnt} !== {32'd1, 32'd0, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL rstmid_counters pkt=%0d drop=%0d hdr_err=%0d len_err=%0d exp 1/0/1/0",
               pkt_cnt, drop_cnt, hdr_err_cnt, len_err_cnt);
    end
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    test_reset();
    test_single();
    test_drop_bm0();
    test_no_hdr();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    drive(1'b0, 8'h00, 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
